// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a one-word output buffer.
// Words leave over a valid/ready handshake; a sticky flag marks any dropped word.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             si_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int CW = (WIDTH > 8) ? $clog2(WIDTH) : 3;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             pov_q, pov_d;
  logic             ovf_q, ovf_d;

  logic [CW-1:0]    base;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             free;
  logic             drop;

  // Shift stage; sync restarts the word so the current bit becomes bit 0
  always_comb begin
    base  = sync ? '0 : cnt_q;
    src   = sync ? '0 : sh_q;
    word  = MSB_FIRST ? {src[WIDTH-2:0], si}
                      : {si, src[WIDTH-1:1]};
    done  = si_valid && (base == LAST);
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (si_valid) begin
      sh_d  = word;
      cnt_d = done ? '0 : base + ONE;
    end else if (sync) begin
      sh_d  = '0;
      cnt_d = '0;
    end
  end

  // Output buffer: a word loads when the slot is empty or draining now
  always_comb begin
    free  = !pov_q || po_ready;
    drop  = done && !free;
    po_d  = po_q;
    pov_d = pov_q;
    if (done && free) begin
      po_d  = word;
      pov_d = 1'b1;
    end else if (pov_q && po_ready) begin
      pov_d = 1'b0;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      po_q  <= '0;
      pov_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      po_q  <= po_d;
      pov_q <= pov_d;
      ovf_q <= ovf_d;
    end
  end

  assign po       = po_q;
  assign po_valid = pov_q;
  assign overflow = ovf_q;
  assign busy     = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: a 4-bit MSB-first instance
// driven from a vector table, plus an 8-bit LSB-first instance.
module tb_sipo_deser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       si, si_valid, sync, po_ready, ovf_clr;
  logic [3:0] po;
  logic       po_valid, busy, overflow;

  logic       si8, si_valid8, sync8, po_ready8, ovf_clr8;
  logic [7:0] po8;
  logic       po_valid8, busy8, overflow8;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n),
    .si(si), .si_valid(si_valid), .sync(sync),
    .po(po), .po_valid(po_valid), .po_ready(po_ready),
    .busy(busy), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n),
    .si(si8), .si_valid(si_valid8), .sync(sync8),
    .po(po8), .po_valid(po_valid8), .po_ready(po_ready8),
    .busy(busy8), .overflow(overflow8), .ovf_clr(ovf_clr8)
  );

  typedef struct {
    logic       v, s, sy, rdy, clr;
    logic [3:0] po;
    logic       pov, busy, ovf;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, s, sy, rdy, clr,
                     input logic [3:0] epo,
                     input logic epov, ebusy, eovf);
    vec_t x;
    x.v = v; x.s = s; x.sy = sy; x.rdy = rdy; x.clr = clr;
    x.po = epo; x.pov = epov; x.busy = ebusy; x.ovf = eovf;
    vecs.push_back(x);
  endtask

  task automatic step4(input logic v, s, sy, rdy, clr);
    @(negedge clk);
    si_valid = v; si = s; sync = sy;
    po_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic step8(input logic v, s);
    @(negedge clk);
    si_valid8 = v; si8 = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  v  si sy rdy clr  po     pov busy ovf
    add(0, 0, 0, 1, 0, 4'b1010, 0, 0, 0);
    add(1, 1, 0, 1, 0, 4'b1010, 0, 1, 0);
    add(1, 0, 0, 1, 0, 4'b1010, 0, 1, 0);
    add(1, 1, 0, 1, 0, 4'b1010, 0, 1, 0);
    add(1, 0, 0, 1, 0, 4'b1010, 1, 0, 0);
    add(1, 0, 0, 1, 0, 4'b1010, 0, 1, 0);
    add(1, 1, 0, 1, 0, 4'b1010, 0, 1, 0);
    add(1, 0, 0, 1, 0, 4'b1010, 0, 1, 0);
    add(1, 1, 0, 1, 0, 4'b0101, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'b0101, 0, 0, 0);
    add(1, 1, 0, 0, 0, 4'b0101, 0, 1, 0);
    add(1, 1, 0, 0, 0, 4'b0101, 0, 1, 0);
    add(0, 0, 0, 0, 0, 4'b0101, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'b0101, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'b1100, 1, 0, 0);
    add(1, 0, 0, 0, 0, 4'b1100, 1, 1, 0);
    add(1, 0, 0, 0, 0, 4'b1100, 1, 1, 0);
    add(1, 1, 0, 0, 0, 4'b1100, 1, 1, 0);
    add(1, 1, 0, 0, 0, 4'b1100, 1, 0, 1);
    add(1, 1, 0, 0, 1, 4'b1100, 1, 1, 0);
    add(1, 1, 0, 0, 1, 4'b1100, 1, 1, 0);
    add(1, 1, 0, 0, 1, 4'b1100, 1, 1, 0);
    add(1, 1, 0, 0, 1, 4'b1100, 1, 0, 1);
    add(0, 0, 0, 1, 1, 4'b1100, 0, 0, 0);
    add(1, 0, 0, 1, 0, 4'b1100, 0, 1, 0);
    add(1, 0, 0, 1, 0, 4'b1100, 0, 1, 0);
    add(1, 1, 0, 1, 0, 4'b1100, 0, 1, 0);
    add(1, 1, 0, 1, 0, 4'b0011, 1, 0, 0);
    add(1, 0, 0, 1, 0, 4'b0011, 0, 1, 0);
    add(1, 1, 0, 1, 0, 4'b0011, 0, 1, 0);
    add(1, 0, 0, 1, 0, 4'b0011, 0, 1, 0);
    add(1, 1, 0, 1, 0, 4'b0101, 1, 0, 0);
    add(1, 1, 0, 1, 0, 4'b0101, 0, 1, 0);
    add(1, 1, 0, 1, 0, 4'b0101, 0, 1, 0);
    add(1, 1, 0, 1, 0, 4'b0101, 0, 1, 0);
    add(1, 0, 0, 1, 0, 4'b1110, 1, 0, 0);
    add(1, 1, 0, 0, 0, 4'b1110, 1, 1, 0);
    add(1, 0, 0, 0, 0, 4'b1110, 1, 1, 0);
    add(1, 0, 0, 0, 0, 4'b1110, 1, 1, 0);
    add(1, 1, 0, 1, 0, 4'b1001, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'b1001, 0, 0, 0);
    add(1, 1, 0, 0, 0, 4'b1001, 0, 1, 0);
    add(1, 1, 0, 0, 0, 4'b1001, 0, 1, 0);
    add(0, 0, 1, 0, 0, 4'b1001, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4'b1001, 0, 1, 0);
    add(1, 1, 0, 0, 0, 4'b1001, 0, 1, 0);
    add(1, 1, 0, 0, 0, 4'b1001, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'b0110, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'b0110, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4'b0110, 0, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0110, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'b0110, 0, 1, 0);
    add(1, 0, 0, 0, 0, 4'b0110, 0, 1, 0);
    add(1, 1, 0, 0, 0, 4'b1001, 1, 0, 0);
    add(0, 0, 1, 0, 0, 4'b1001, 1, 0, 0);

    rst_n = 1'b0;
    si = 0; si_valid = 0; sync = 0; po_ready = 0; ovf_clr = 0;
    si8 = 0; si_valid8 = 0; sync8 = 0; po_ready8 = 0; ovf_clr8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_po", 32'(po), 32'h0);
    chk("rst_pov", 32'(po_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_po8", 32'(po8), 32'h0);
    chk("rst_busy8", 32'(busy8), 32'h0);

    step4(1, 1, 0, 0, 0);
    step4(1, 1, 0, 0, 0);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    @(negedge clk);
    si_valid = 0;
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step4(1, 1, 0, 0, 0);
    step4(1, 0, 0, 0, 0);
    step4(1, 1, 0, 0, 0);
    chk("rst_w_pov3", 32'(po_valid), 32'h0);
    step4(1, 0, 0, 0, 0);
    chk("rst_w_po", 32'(po), 32'hA);
    chk("rst_w_pov", 32'(po_valid), 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      step4(vecs[i].v, vecs[i].s, vecs[i].sy,
            vecs[i].rdy, vecs[i].clr);
      chk($sformatf("v%0d_po", i), 32'(po), 32'(vecs[i].po));
      chk($sformatf("v%0d_pov", i), 32'(po_valid),
          32'(vecs[i].pov));
      chk($sformatf("v%0d_busy", i), 32'(busy),
          32'(vecs[i].busy));
      chk($sformatf("v%0d_ovf", i), 32'(overflow),
          32'(vecs[i].ovf));
    end

    for (int k = 0; k < 8; k++) begin
      step8(1'b1, (k == 0));
      chk($sformatf("w8_busy%0d", k), 32'(busy8),
          (k < 7) ? 32'h1 : 32'h0);
      chk($sformatf("w8_pov%0d", k), 32'(po_valid8),
          (k < 7) ? 32'h0 : 32'h1);
    end
    chk("w8_po", 32'(po8), 32'h01);
    chk("w8_ovf", 32'(overflow8), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
